// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, drives the program ROM, assembles
// opcode (+ optional operand) into one instruction and hands it to execute
// over a valid/ready handshake. Handles branch redirects and HALT.
module ifetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic       halted
);

  typedef enum logic [2:0] {
    ISSUE = 3'd0,
    OPC   = 3'd1,
    OPR   = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t state;

  // Opcodes 0x2_..0xA_ carry a second (operand) byte.
  function automatic logic needs_operand(input logic [7:0] opc);
    return (opc[7:4] >= 4'h2) && (opc[7:4] <= 4'hA);
  endfunction

  // ROM address tracks the PC directly; the ROM registers it.
  assign rom_addr = pc;

  // Fetch FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      ir          <= 8'h00;
      operand     <= 8'h00;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          // ROM latches the opcode address at this edge.
          pc    <= pc + 8'd1;
          state <= OPC;
        end
        OPC: begin
          ir <= rom_data;
          if (needs_operand(rom_data)) begin
            // pc already points at the operand byte; ROM latches it now.
            pc    <= pc + 8'd1;
            state <= OPR;
          end else begin
            operand     <= 8'h00;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        OPR: begin
          operand     <= rom_data;
          instr_valid <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (ir[7:4] == HALT_OPC) begin
              // HALT wins over any branch request on the same handshake.
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              if (branch_taken) pc <= branch_target;
              state <= ISSUE;
            end
          end
        end
        HALT: begin
          // Parked until reset.
          halted      <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a table of expected instructions walked
// in order, plus hand-written HALT, reset-in-flight and PC-wrap sequences.
module tb_ifetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rom_addr, rom_data, pc, ir, operand, branch_target;
  logic       instr_valid, instr_ready, branch_taken, halted;

  logic [7:0] rom_addr2, rom_data2, pc2, ir2, operand2;
  logic       instr_valid2, halted2;
  logic       ready2 = 1'b0;

  logic [7:0] rom  [256];
  logic [7:0] rom2 [256];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Registered-read program ROMs (one cycle latency).
  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  ifetch dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .pc(pc), .ir(ir), .operand(operand), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .halted(halted)
  );

  ifetch #(.RESET_PC(8'hFF), .HALT_OPC(4'hF)) dut_wrap (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .pc(pc2), .ir(ir2), .operand(operand2), .instr_valid(instr_valid2),
    .instr_ready(ready2), .branch_taken(branch_taken),
    .branch_target(branch_target), .halted(halted2)
  );

  typedef struct {
    logic [7:0] exp_ir;
    logic [7:0] exp_opr;
    logic [7:0] exp_pc;
    int         exp_lat;
    int         hold;
    logic       br;
    logic [7:0] tgt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Enter with the DUT #1 after the edge that put it in ISSUE.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!instr_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat;
    string tag;
    tag = $sformatf("v%0d", k);
    wait_valid(lat);
    chk({tag, " valid"},   instr_valid, 1);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " ir"},      ir, v.exp_ir);
    chk({tag, " operand"}, operand, v.exp_opr);
    chk({tag, " pc"},      pc, v.exp_pc);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, instr_valid, 1);
      chk({tag, " hold ir"},    ir, v.exp_ir);
      chk({tag, " hold opr"},   operand, v.exp_opr);
      chk({tag, " hold pc"},    pc, v.exp_pc);
    end
    instr_ready   = 1'b1;
    branch_taken  = v.br;
    branch_target = v.tgt;
    @(posedge clk); #1;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    chk({tag, " accepted"}, instr_valid, 0);
    chk({tag, " pc after"}, pc, v.br ? v.tgt : v.exp_pc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    for (int a = 0; a < 256; a++) begin rom[a] = 8'hEE; rom2[a] = 8'hEE; end
    rom[8'h00] = 8'h10;
    rom[8'h01] = 8'h20; rom[8'h02] = 8'h05;
    rom[8'h03] = 8'hC1;
    rom[8'h04] = 8'h80; rom[8'h05] = 8'h00;
    rom[8'h06] = 8'h40; rom[8'h07] = 8'h07;
    rom[8'h08] = 8'h3A; rom[8'h09] = 8'hFF;
    rom[8'h0A] = 8'hA5; rom[8'h0B] = 8'h12;
    rom[8'h0C] = 8'h1F;
    rom[8'h0D] = 8'hB0;
    rom[8'h20] = 8'h2C; rom[8'h21] = 8'h77;
    rom[8'h22] = 8'hF0;
    rom2[8'hFF] = 8'h40; rom2[8'h00] = 8'h09;

    //            ir     opr    pc    lat hold br    tgt
    vecs[0]  = '{8'h10, 8'h00, 8'h01, 2, 0, 1'b0, 8'h00};
    vecs[1]  = '{8'h20, 8'h05, 8'h03, 3, 0, 1'b0, 8'h00};
    vecs[2]  = '{8'hC1, 8'h00, 8'h04, 2, 0, 1'b0, 8'h00};
    vecs[3]  = '{8'h80, 8'h00, 8'h06, 3, 0, 1'b1, 8'h00};
    vecs[4]  = '{8'h10, 8'h00, 8'h01, 2, 0, 1'b0, 8'h00};
    vecs[5]  = '{8'h20, 8'h05, 8'h03, 3, 0, 1'b0, 8'h00};
    vecs[6]  = '{8'hC1, 8'h00, 8'h04, 2, 0, 1'b0, 8'h00};
    vecs[7]  = '{8'h80, 8'h00, 8'h06, 3, 0, 1'b0, 8'h00};
    vecs[8]  = '{8'h40, 8'h07, 8'h08, 3, 5, 1'b0, 8'h00};
    vecs[9]  = '{8'h3A, 8'hFF, 8'h0A, 3, 0, 1'b0, 8'h00};
    vecs[10] = '{8'hA5, 8'h12, 8'h0C, 3, 0, 1'b0, 8'h00};
    vecs[11] = '{8'h1F, 8'h00, 8'h0D, 2, 0, 1'b0, 8'h00};
    vecs[12] = '{8'hB0, 8'h00, 8'h0E, 2, 0, 1'b1, 8'h20};
    vecs[13] = '{8'h2C, 8'h77, 8'h22, 3, 0, 1'b0, 8'h00};

    @(posedge clk); #1;
    do_reset();
    chk("reset pc",      pc, 8'h00);
    chk("reset ir",      ir, 8'h00);
    chk("reset operand", operand, 8'h00);
    chk("reset valid",   instr_valid, 0);
    chk("reset halted",  halted, 0);
    chk("reset pc wrapdut", pc2, 8'hFF);

    for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

    // HALT at 22: branch request on the same handshake must be ignored.
    wait_valid(lat);
    chk("halt latency", lat, 2);
    chk("halt ir", ir, 8'hF0);
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h55;
    @(posedge clk); #1;
    instr_ready = 1'b0; branch_taken = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("halt halted", halted, 1);
      chk("halt valid",  instr_valid, 0);
      chk("halt pc",     pc, 8'h23);
      instr_ready = c[0];
      @(posedge clk); #1;
    end
    instr_ready = 1'b0;
    do_reset();
    chk("unhalt halted", halted, 0);
    chk("unhalt pc",     pc, 8'h00);
    chk("unhalt valid",  instr_valid, 0);
    run_vec(100, vecs[0]);

    // Reset while in OPR of 01:20 05.
    @(posedge clk); #1;   // OPC
    @(posedge clk); #1;   // OPR
    chk("mid pc", pc, 8'h03);
    do_reset();
    chk("midrst valid",   instr_valid, 0);
    chk("midrst ir",      ir, 8'h00);
    chk("midrst operand", operand, 8'h00);
    chk("midrst pc",      pc, 8'h00);
    run_vec(101, vecs[0]);

    // Wrap DUT: RESET_PC=FF, operand read from 00, pc ends at 01.
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    chk("wrap valid",   instr_valid2, 1);
    chk("wrap ir",      ir2, 8'h40);
    chk("wrap operand", operand2, 8'h09);
    chk("wrap pc",      pc2, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
